// File: rtl/nco_est_pkg.sv
// Shared constants for the NCO phase/frequency estimator: CORDIC atan table and datapath widths.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package nco_est_pkg;

    // Default I/Q width and the guard bits added in front of the CORDIC datapath.
    localparam int NCO_MPR           = 18;
    localparam int CORDIC_GUARD_BITS = 2;
    localparam int CORDIC_XY_W       = NCO_MPR + CORDIC_GUARD_BITS;

    typedef logic signed [CORDIC_XY_W-1:0] cordic_xy_t;

    // round(atan(2^-idx) / (2*pi) * 2^32); shorter phase words take the upper bits.
    function automatic logic [31:0] atan_lut(input int idx);
        logic [31:0] v;
        v = 32'h0000_0000;
        case (idx)
            0:  v = 32'h2000_0000;
            1:  v = 32'h12E4_051E;
            2:  v = 32'h09FB_385B;
            3:  v = 32'h0511_11D4;
            4:  v = 32'h028B_0D43;
            5:  v = 32'h0145_D7E1;
            6:  v = 32'h00A2_F61E;
            7:  v = 32'h0051_7C55;
            8:  v = 32'h0028_BE53;
            9:  v = 32'h0014_5F2F;
            10: v = 32'h000A_2F98;
            11: v = 32'h0005_17CC;
            12: v = 32'h0002_8BE6;
            13: v = 32'h0001_45F3;
            14: v = 32'h0000_A2FA;
            15: v = 32'h0000_517D;
            16: v = 32'h0000_28BE;
            17: v = 32'h0000_145F;
            18: v = 32'h0000_0A30;
            19: v = 32'h0000_0518;
            20: v = 32'h0000_028C;
            21: v = 32'h0000_0146;
            22: v = 32'h0000_00A3;
            23: v = 32'h0000_0051;
            24: v = 32'h0000_0029;
            25: v = 32'h0000_0014;
            26: v = 32'h0000_000A;
            27: v = 32'h0000_0005;
            28: v = 32'h0000_0003;
            29: v = 32'h0000_0001;
            30: v = 32'h0000_0001;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/iq_cordic_vec_stage.sv
// One registered CORDIC vectoring micro-rotation driving y toward zero and accumulating the angle in z.
// Latency: 1 enabled cycle; valid and zero flag travel alongside the data.
// Backpressure: none; advances on every clken cycle, holds otherwise.
module iq_cordic_vec_stage
    import nco_est_pkg::*;
#(
    parameter int xy_w  = 20,
    parameter int apr   = 32,
    parameter int shift = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clken,
    input  logic                   in_valid,
    input  logic                   in_zero,
    input  logic signed [xy_w-1:0] x_i,
    input  logic signed [xy_w-1:0] y_i,
    input  logic        [apr-1:0]  z_i,
    output logic                   out_valid,
    output logic                   out_zero,
    output logic signed [xy_w-1:0] x_o,
    output logic signed [xy_w-1:0] y_o,
    output logic        [apr-1:0]  z_o
);

    localparam logic [31:0]    ATAN_FULL = atan_lut(shift) >> (32 - apr);
    localparam logic [apr-1:0] ATAN_I    = ATAN_FULL[apr-1:0];

    logic signed [xy_w-1:0] x_sh;
    logic signed [xy_w-1:0] y_sh;

    assign x_sh = x_i >>> shift;
    assign y_sh = y_i >>> shift;

    // Rotate toward the x axis: positive turn when y is negative, and book the opposite angle in z.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            x_o       <= '0;
            y_o       <= '0;
            z_o       <= '0;
        end else if (clken) begin
            out_valid <= in_valid;
            out_zero  <= in_zero;
            if (y_i[xy_w-1]) begin
                x_o <= x_i - y_sh;
                y_o <= y_i + x_sh;
                z_o <= z_i - ATAN_I;
            end else begin
                x_o <= x_i + y_sh;
                y_o <= y_i - x_sh;
                z_o <= z_i + ATAN_I;
            end
        end
    end

endmodule

// File: rtl/iq_phase_inc_est.sv
// Recovers instantaneous phase from I/Q (CORDIC vectoring) and averages successive phase differences.
// Latency: phase iters+2 enabled cycles; increment 2 enabled cycles after the phase completing the block.
// Backpressure: none; one sample per enabled cycle, everything freezes while clken is low.
module iq_phase_inc_est
    import nco_est_pkg::*;
#(
    parameter int mpr      = 18,
    parameter int apr      = 32,
    parameter int iters    = 16,
    parameter int avg_log2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  in_valid,
    input  logic signed [mpr-1:0] fcos_i,
    input  logic signed [mpr-1:0] fsin_i,
    output logic        [apr-1:0] phi_o,
    output logic                  out_valid,
    output logic        [apr-1:0] phi_inc_o,
    output logic                  inc_valid
);

    localparam int XY_W  = mpr + CORDIC_GUARD_BITS;
    localparam int ACC_W = apr + avg_log2;
    localparam int CNT_W = (avg_log2 > 0) ? avg_log2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << avg_log2) - 1);
    localparam logic [apr-1:0]   HALF_TURN = {1'b1, {(apr-1){1'b0}}};

    // Guard bits absorb negating the most negative input and the ~1.647 CORDIC gain.
    logic signed [XY_W-1:0] i_ext;
    logic signed [XY_W-1:0] q_ext;
    assign i_ext = {{CORDIC_GUARD_BITS{fcos_i[mpr-1]}}, fcos_i};
    assign q_ext = {{CORDIC_GUARD_BITS{fsin_i[mpr-1]}}, fsin_i};

    logic signed [XY_W-1:0] x0, y0;
    logic        [apr-1:0]  z0;
    logic                   v0, zf0;

    // Pre-rotation: fold the left half-plane onto the right by a half turn so the CORDIC converges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0  <= 1'b0;
            zf0 <= 1'b0;
            x0  <= '0;
            y0  <= '0;
            z0  <= '0;
        end else if (clken) begin
            v0  <= in_valid;
            zf0 <= (fcos_i == '0) && (fsin_i == '0);
            if (fcos_i[mpr-1]) begin
                x0 <= -i_ext;
                y0 <= -q_ext;
                z0 <= HALF_TURN;
            end else begin
                x0 <= i_ext;
                y0 <= q_ext;
                z0 <= '0;
            end
        end
    end

    // Element k feeds micro-rotation k; element iters is the last stage's result.
    logic signed [XY_W-1:0] xs [0:iters];
    logic signed [XY_W-1:0] ys [0:iters];
    logic        [apr-1:0]  zs [0:iters];
    logic                   vs [0:iters];
    logic                   zf [0:iters];

    assign xs[0] = x0;
    assign ys[0] = y0;
    assign zs[0] = z0;
    assign vs[0] = v0;
    assign zf[0] = zf0;

    for (genvar k = 0; k < iters; k++) begin : g_stage
        iq_cordic_vec_stage #(
            .xy_w  (XY_W),
            .apr   (apr),
            .shift (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .clken     (clken),
            .in_valid  (vs[k]),
            .in_zero   (zf[k]),
            .x_i       (xs[k]),
            .y_i       (ys[k]),
            .z_i       (zs[k]),
            .out_valid (vs[k+1]),
            .out_zero  (zf[k+1]),
            .x_o       (xs[k+1]),
            .y_o       (ys[k+1]),
            .z_o       (zs[k+1])
        );
    end

    // Output stage: the angle of a zero vector is undefined, so report 0 for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            phi_o     <= '0;
        end else if (clken) begin
            out_valid <= vs[iters];
            phi_o     <= zf[iters] ? '0 : zs[iters];
        end
    end

    logic        [apr-1:0] phi_prev;
    logic                  prev_ok;
    logic signed [apr-1:0] diff;
    logic                  diff_vld;

    // Differentiator: modulo subtraction makes phase wrap invisible; the first phase only primes phi_prev.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi_prev <= '0;
            prev_ok  <= 1'b0;
            diff     <= '0;
            diff_vld <= 1'b0;
        end else if (clken) begin
            diff_vld <= out_valid && prev_ok;
            if (out_valid) begin
                phi_prev <= phi_o;
                prev_ok  <= 1'b1;
                diff     <= phi_o - phi_prev;
            end
        end
    end

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic        [CNT_W-1:0] cnt;

    assign acc_sum = acc + ACC_W'(diff);

    // Averager: sum 2^avg_log2 differences, publish the truncated mean, then restart from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            phi_inc_o <= '0;
            inc_valid <= 1'b0;
        end else if (clken) begin
            inc_valid <= 1'b0;
            if (diff_vld) begin
                if (cnt == CNT_LAST) begin
                    phi_inc_o <= acc_sum[ACC_W-1:avg_log2];
                    inc_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/iq_phase_inc_est.md
# iq_phase_inc_est

Phase and frequency estimator: the inverse of the NCO. It takes I/Q samples (cos/sin pairs in the NCO output format) and recovers the instantaneous phase with a pipelined CORDIC in vectoring mode. It differentiates successive phases and averages the result into a phase-increment estimate scaled like the NCO's `phi_inc_i`. It sits downstream of the NCO/mixer chain and closes the loop for frequency measurement and NCO self-test.

## Interface
Parameters:
- `mpr`, 18: I/Q input width, signed two's complement.
- `apr`, 32: phase and increment width; 2^apr = one full turn (same scaling as the NCO accumulator).
- `iters`, 16: number of CORDIC micro-rotation stages, range 8..apr-2.
- `avg_log2`, 4: number of averaged differences is 2^avg_log2, range 0..8.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `clken`, in, 1: global clock enable; when 0, every register holds.
- `in_valid`, in, 1: `fcos_i`/`fsin_i` carry a sample.
- `fcos_i`, in, mpr: I component, signed.
- `fsin_i`, in, mpr: Q component, signed.
- `phi_o`, out, apr: instantaneous phase, unsigned fraction of a turn.
- `out_valid`, out, 1: `phi_o` is valid.
- `phi_inc_o`, out, apr: averaged phase increment, signed.
- `inc_valid`, out, 1: `phi_inc_o` updated this cycle (one enabled-cycle pulse).

## Operation
- All registers advance only on cycles with `clken`=1. Consumers qualify `out_valid`/`inc_valid` with `clken`. A valid bit travels with each pipeline stage; bubbles (`in_valid`=0) propagate unchanged.
- Stage 0 (pre-rotation):
  - Sign-extend I and Q to mpr+2 bits. The 2 guard bits absorb negation of -2^(mpr-1) and the CORDIC gain of ≈1.647.
  - If I<0, negate both components and set z=2^(apr-1); otherwise z=0.
  - Register a zero flag when I=Q=0.
- Stages 1..iters (micro-rotation i=0..iters-1):
  - d = +1 if y<0, else -1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan_i.
  - atan_i = round(atan(2^-i)/(2π)·2^apr).
- Output stage: phi_o = z mod 2^apr, or 0 if the zero flag is set. Wrap-around is natural modulo 2^apr.
- Differentiator:
  - On each valid phase with `prev_ok`=1: diff = phi − phi_prev mod 2^apr, interpreted signed. Store phi_prev.
  - The first valid phase after reset only loads phi_prev and sets `prev_ok`; it produces no diff.
- Averager:
  - Accumulator of apr+avg_log2 bits, signed, and a counter of avg_log2 bits.
  - Each diff is added. When the counter wraps from 2^avg_log2−1 to 0, `phi_inc_o` = acc >>> avg_log2 (arithmetic shift, truncation), `inc_valid` pulses, and the accumulator restarts with the next diff.
- Accuracy: |phi_o error| ≤ 2^(apr-iters) LSB for inputs with magnitude ≥ 2^(mpr-4). `phi_inc_o` error ≤ 2^(apr-iters-avg_log2+1) LSB for a constant-frequency input.

## Timing
- Reset values: `phi_o`=0, `out_valid`=0, `phi_inc_o`=0, `inc_valid`=0. Also cleared: all pipeline valids, `prev_ok`, accumulator, counter.
- Phase latency: `out_valid` asserts iters+2 enabled cycles after the `in_valid` sample (stage 0, iters stages, output stage).
- Increment latency: `inc_valid` asserts 2 enabled cycles after the `out_valid` of the sample completing the 2^avg_log2-th diff (diff register, then accumulator/output register).
- Throughput: one sample per enabled cycle, with no back-pressure.
- Reset asserted mid-stream: in-flight samples are discarded, and the next sample after release behaves as the first sample after reset.
- `clken`=0 mid-stream: state freezes exactly; resuming gives results bit-identical to an unstalled run.

## Structure
- Shared package `nco_est_pkg` holds:
  - The atan table as apr-bit constants (entry 0 = 2^(apr-3)), generated for apr=32 and truncated for smaller apr.
  - A `cordic_xy_t` width constant (mpr+2).
- Sub-module `iq_cordic_vec_stage` implements one registered micro-rotation (shift index as a parameter, with valid and zero-flag pass-through). It is instantiated `iters` times by a generate loop.
- The top level holds the pre-rotation, output stage, differentiator, and averager.

## Test plan
- Quadrants: I/Q = (+100000,0), (0,+100000), (−100000,0), (0,−100000) → `phi_o` = 0x00000000, 0x40000000, 0x80000000, 0xC0000000 (±65536). `out_valid` appears 18 cycles after input.
- Extremes and zero:
  - (−131072,−131072) → 0xA0000000 ±65536, with no overflow.
  - (0,0) → `phi_o`=0.
- Positive frequency: feed the NCO output with `phi_inc_i`=0x01000000, continuous valid → first `inc_valid` after 17 samples, `phi_inc_o`=0x01000000 ±8192, repeating every 16 samples.
- Negative frequency with wrap: `phi_inc_i`=0xF0000000 → `phi_inc_o`=0xF0000000 ±8192, with no glitch at phase wrap.
- Gaps and stalls: random `in_valid` gaps plus random `clken`=0 cycles → output sequence identical to the gap-free reference run.
- Reset mid-stream: assert `reset` 5 cycles into a stream → all outputs 0 immediately; after release the first `inc_valid` again needs 17 valid samples.
